track_sensor_conditioner: RTL

Front-end stage for the railway crossing controller. It conditions two raw track-side sensors: sensor A on the approach side, sensor B on the far side. Each sensor is synchronised and debounced, then a direction-aware occupancy state machine runs on the clean signals. Its `train_present` output drives the `sw1` input of `railway` directly; it also reports direction, completed passages, and a fail-safe fault.

---
 rtl/track_sensor_conditioner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/track_sensor_conditioner.sv
// Track sensor front end: synchronise and debounce two track sensors, then track direction-aware occupancy.
// Define TRACK_SENSOR_TIMEOUT_EN to add the occupancy timeout that forces FAULT.
module track_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sens_a,
    input  logic             sens_b,
    output logic             train_present,
    output logic             dir,
    output logic             pass_pulse,
    output logic [CNT_W-1:0] pass_count,
    output logic             fault
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    if (DEBOUNCE_CYCLES == 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("track_sensor_conditioner: need DEBOUNCE_CYCLES >= 1 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OCC_AB = 2'd1,
        OCC_BA = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // Bit 0 is sensor A, bit 1 is sensor B throughout.
    logic [1:0]      sync_q1;
    logic [1:0]      sync_q2;
    logic [1:0]      lvl;
    logic [1:0]      rise;
    logic [DB_W-1:0] db_cnt [2];

    state_t state;
    state_t state_n;
    logic   pass_c;
    logic   dir_c;
    logic   timeout_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {sens_b, sens_a};
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: the level flips once the synchronised input has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl    <= '0;
            rise   <= '0;
            db_cnt <= '{default: '0};
        end else begin
            rise <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    lvl[i]    <= ~lvl[i];
                    rise[i]   <= ~lvl[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

`ifdef TRACK_SENSOR_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] occ_timer;

    assign timeout_c = (occ_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent in one occupancy; zero on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_timer <= '0;
        end else if ((state == OCC_AB || state == OCC_BA) && state_n == state) begin
            occ_timer <= occ_timer + TMR_W'(1);
        end else begin
            occ_timer <= '0;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pass_c  = 1'b0;
        dir_c   = dir;
        case (state)
            IDLE: begin
                if (rise[0] && rise[1]) begin
                    state_n = FAULT;
                end else if (rise[0]) begin
                    state_n = OCC_AB;
                    dir_c   = 1'b0;
                end else if (rise[1]) begin
                    state_n = OCC_BA;
                    dir_c   = 1'b1;
                end
            end
            OCC_AB: begin
                if (rise[1]) begin
                    state_n = IDLE;
                    pass_c  = 1'b1;
                end else if (timeout_c) begin
                    state_n = FAULT;
                end
            end
            OCC_BA: begin
                if (rise[0]) begin
                    state_n = IDLE;
                    pass_c  = 1'b1;
                end else if (timeout_c) begin
                    state_n = FAULT;
                end
            end
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
    end

    // FAULT keeps train_present high so the crossing stays closed.
    always_ff @(posedge clk) begin
        if (reset) begin
            train_present <= 1'b0;
            dir           <= 1'b0;
            pass_pulse    <= 1'b0;
            pass_count    <= '0;
            fault         <= 1'b0;
        end else begin
            train_present <= (state_n != IDLE);
            dir           <= dir_c;
            pass_pulse    <= pass_c;
            fault         <= (state_n == FAULT);
            if (pass_c) begin
                pass_count <= pass_count + CNT_W'(1);
            end
        end
    end

endmodule
